// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a uart_8n1 transmitter: producers push bytes at any rate, the
// sequencer drains them one frame at a time over the tx_data/tx_start/tx_busy handshake.
module uart_tx_fifo #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              hclk,
    input  logic              rst_n,
    input  logic [7:0]        wr_data,
    input  logic              wr_en,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_C     = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ZERO_C  = (ADDR_W + 1)'(0);
    localparam logic [ADDR_W:0]   CNT_ONE_C   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ZERO_C  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] PTR_ONE_C   = ADDR_W'(1);
    localparam logic [8:0]        ACK_LIMIT_C = 9'(ACK_TIMEOUT);

    logic [7:0]        mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   count_r;
    logic              overflow_r;
    state_t            state_r;
    logic [7:0]        tx_data_r;
    logic              tx_start_r;
    logic [7:0]        ack_cnt_r;

    logic              full_s;
    logic              empty_s;
    logic              wr_accept_s;
    logic              pop_s;
    logic [8:0]        ack_cnt_inc_s;

    // Flags decode from the registered count; a write is judged against registered full.
    always_comb begin
        full_s        = (count_r == DEPTH_C);
        empty_s       = (count_r == CNT_ZERO_C);
        wr_accept_s   = wr_en & ~full_s;
        pop_s         = (state_r == ST_WAIT_ACK) & tx_busy;
        ack_cnt_inc_s = {1'b0, ack_cnt_r} + 9'd1;
    end

    // Storage array; contents are deliberately left out of reset.
    always_ff @(posedge hclk) begin
        if (rst_n && wr_accept_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge hclk) begin
        if (!rst_n) begin
            wr_ptr_r   <= PTR_ZERO_C;
            rd_ptr_r   <= PTR_ZERO_C;
            count_r    <= CNT_ZERO_C;
            overflow_r <= 1'b0;
        end else begin
            if (wr_accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            case ({wr_accept_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE_C;
                2'b01:   count_r <= count_r - CNT_ONE_C;
                default: count_r <= count_r;
            endcase
            if (wr_en && full_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Transmit sequencer; the byte is only popped once the transmitter raises busy,
    // so a start strobe that is never acknowledged is retried with the same byte.
    always_ff @(posedge hclk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            tx_data_r  <= 8'h00;
            tx_start_r <= 1'b0;
            ack_cnt_r  <= 8'h00;
        end else begin
            tx_start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (!empty_s && !tx_busy) begin
                        tx_data_r  <= mem_r[rd_ptr_r];
                        tx_start_r <= 1'b1;
                        state_r    <= ST_START;
                    end
                end
                ST_START: begin
                    ack_cnt_r <= 8'h00;
                    state_r   <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (tx_busy) begin
                        state_r <= ST_WAIT_DONE;
                    end else if (ack_cnt_inc_s >= ACK_LIMIT_C) begin
                        state_r <= ST_IDLE;
                    end else begin
                        ack_cnt_r <= ack_cnt_inc_s[7:0];
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign full     = full_s;
    assign empty    = empty_s;
    assign count    = count_r;
    assign overflow = overflow_r;
    assign tx_data  = tx_data_r;
    assign tx_start = tx_start_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected bytes, a forked monitor
// checks each acknowledged tx_start against the queue head.
module tb_uart_tx_fifo;

    localparam int DEPTH       = 16;
    localparam int ADDR_W      = 4;
    localparam int ACK_TIMEOUT = 255;

    logic              hclk       = 1'b0;
    logic              rst_n      = 1'b0;
    logic [7:0]        wr_data    = 8'h00;
    logic              wr_en      = 1'b0;
    logic              force_busy = 1'b0;
    logic              model_en   = 1'b1;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_busy;

    int checks   = 0;
    int errors   = 0;
    int busy_cnt = 0;
    int cyc      = 0;
    logic [7:0] exp_q [$];

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .hclk     (hclk),
        .rst_n    (rst_n),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy)
    );

    always #5 hclk = ~hclk;

    always @(posedge hclk) cyc <= cyc + 1;

    // Transmitter model: busy rises the cycle after tx_start and stays up 20 cycles.
    always @(posedge hclk) begin
        if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        else if (model_en && tx_start) busy_cnt <= 20;
    end

    assign tx_busy = force_busy | (busy_cnt != 0);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge hclk);
            if (rst_n && tx_start && model_en) begin
                chk("start_while_busy", int'(tx_busy), 0);
                if (exp_q.size() == 0) chk("sb_underflow", exp_q.size(), 1);
                else chk("tx_data_order", int'(tx_data), int'(exp_q.pop_front()));
            end
        end
    endtask

    // Called at a negedge; returns at the next negedge with the write taken.
    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge hclk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        while (tx_start !== 1'b1 && n < 1000) begin
            @(negedge hclk);
            n++;
        end
        chk("start_seen", int'(n < 1000), 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (!(empty === 1'b1 && tx_busy === 1'b0) && n < 3000) begin
            @(negedge hclk);
            n++;
        end
        chk("drain_done", int'(n < 3000), 1);
        repeat (2) @(negedge hclk);
        chk("sb_leftover", exp_q.size(), 0);
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge hclk);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_tx_start", int'(tx_start), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        rst_n = 1'b1;

        // Single byte: two-cycle write-to-start latency, pop on the ack cycle
        exp_q.push_back(8'h61);
        write_byte(8'h61);
        chk("single_count_after_wr", int'(count), 1);
        chk("single_no_bypass", int'(tx_start), 0);
        @(negedge hclk);
        chk("single_start", int'(tx_start), 1);
        chk("single_data", int'(tx_data), 8'h61);
        @(negedge hclk);
        chk("single_count_pre_ack", int'(count), 1);
        chk("single_start_one_cycle", int'(tx_start), 0);
        @(negedge hclk);
        chk("single_count_ack", int'(count), 0);
        chk("single_empty", int'(empty), 1);
        wait_drain();

        // Burst of 26 while a foreign frame holds busy: 16 kept, 10 dropped
        force_busy = 1'b1;
        for (int i = 0; i < 26; i++) begin
            if (i < DEPTH) exp_q.push_back(8'(8'h61 + i));
            write_byte(8'(8'h61 + i));
        end
        chk("burst_count", int'(count), 16);
        chk("burst_full", int'(full), 1);
        chk("burst_overflow", int'(overflow), 1);
        chk("burst_no_start_busy", int'(tx_start), 0);
        force_busy = 1'b0;
        wait_drain();
        chk("burst_empty", int'(empty), 1);

        // Reset during WAIT_DONE with 3 bytes still queued
        force_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'(8'hA0 + i));
            write_byte(8'(8'hA0 + i));
        end
        force_busy = 1'b0;
        wait_start();
        repeat (2) @(negedge hclk);
        chk("midrst_count_before", int'(count), 3);
        rst_n = 1'b0;
        @(negedge hclk);
        chk("midrst_count", int'(count), 0);
        chk("midrst_empty", int'(empty), 1);
        chk("midrst_tx_start", int'(tx_start), 0);
        chk("midrst_tx_data", int'(tx_data), 0);
        chk("midrst_overflow", int'(overflow), 0);
        exp_q.delete();
        rst_n = 1'b1;
        wait_drain();

        // Full FIFO: write and ack together -> write dropped, count DEPTH-1
        force_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(8'(8'hC0 + i));
            write_byte(8'(8'hC0 + i));
        end
        chk("fullpop_full", int'(full), 1);
        chk("fullpop_ovf_clear", int'(overflow), 0);
        force_busy = 1'b0;
        wait_start();
        @(negedge hclk);
        write_byte(8'hEE);
        chk("fullpop_count", int'(count), DEPTH - 1);
        chk("fullpop_overflow", int'(overflow), 1);
        chk("fullpop_not_full", int'(full), 0);
        wait_drain();

        // count=5: write and ack in the same cycle keep count at 5
        force_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(8'(8'h10 + i));
            write_byte(8'(8'h10 + i));
        end
        chk("simul_count_pre", int'(count), 5);
        force_busy = 1'b0;
        wait_start();
        @(negedge hclk);
        exp_q.push_back(8'h15);
        write_byte(8'h15);
        chk("simul_count", int'(count), 5);
        wait_drain();

        // Ack timeout: no busy response -> same byte re-strobed every ACK_TIMEOUT+2 cycles
        begin
            int t1;
            int t2;
            model_en = 1'b0;
            exp_q.push_back(8'h41);
            write_byte(8'h41);
            wait_start();
            t1 = cyc;
            chk("timeout_data1", int'(tx_data), 8'h41);
            @(negedge hclk);
            wait_start();
            t2 = cyc;
            chk("timeout_period", t2 - t1, ACK_TIMEOUT + 2);
            chk("timeout_data2", int'(tx_data), 8'h41);
            chk("timeout_count", int'(count), 1);
            @(negedge hclk);
            model_en = 1'b1;
            wait_drain();
        end

        // Wrap: 3 rounds of 12 bytes, each drained, crossing the pointer wrap
        for (int r = 0; r < 3; r++) begin
            force_busy = 1'b1;
            for (int i = 0; i < 12; i++) begin
                exp_q.push_back(8'(8'h80 + r * 12 + i));
                write_byte(8'(8'h80 + r * 12 + i));
            end
            chk("wrap_count", int'(count), 12);
            force_busy = 1'b0;
            wait_drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
